// File: rtl/bus_timer_responder.sv
// Memory-mapped countdown timer on the responder side of the CPU data bus.
// Define TIMER_STATUS_EN to add the STATUS register (read + W1C pending) at offset 0xC.
module bus_timer_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00,
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_rdata,
  output logic        hit,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_CTRL    = 2'd0;
  localparam logic [1:0] SEL_PRESET  = 2'd1;
  localparam logic [1:0] SEL_COUNT   = 2'd2;
  localparam logic [1:0] SEL_STATUS  = 2'd3;
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
      else       res[8*i +: 8] = old_v[8*i +: 8];
    end
    return res;
  endfunction

  state_t      state_r;
  logic [3:0]  ctrl_r;
  logic [31:0] preset_r;
  logic [31:0] count_r;
  logic        pending_r;

  logic        hit_s;
  logic [1:0]  sel_s;
  logic        wr_s;
  logic        wr_ctrl_lo_s;
  logic        wr_preset_s;
  logic        set_pending_s;
  logic        reload_s;
  logic        oneshot_s;
  logic        clr_pending_s;
  logic [31:0] rdata_s;
  logic        unused_s;
`ifdef TIMER_STATUS_EN
  logic [31:0] status_s;
`endif

  assign hit_s    = (m_data_addr[31:4] == BASE_ADDR[31:4]);
  assign sel_s    = m_data_addr[3:2];
  assign unused_s = ^m_data_addr[1:0];

  assign hit = hit_s;
  assign IRQ = pending_r & ctrl_r[3];

`ifdef TIMER_STATUS_EN
  assign status_s = {27'd0, pending_r, IRQ, 1'b0, state_r};
`endif

  // Bus write strobes and FSM event decode
  always_comb begin
    wr_s          = hit_s && (m_data_byteen != 4'b0000);
    wr_ctrl_lo_s  = wr_s && (sel_s == SEL_CTRL) && m_data_byteen[0];
    wr_preset_s   = wr_s && (sel_s == SEL_PRESET);
    set_pending_s = (state_r == CNT) && ctrl_r[0] && (count_r <= 32'd1);
    reload_s      = (state_r == INT) && (ctrl_r[2:1] == MODE_RELOAD);
    oneshot_s     = (state_r == INT) && (ctrl_r[2:1] != MODE_RELOAD);
`ifdef TIMER_STATUS_EN
    clr_pending_s = wr_ctrl_lo_s ||
                    (wr_s && (sel_s == SEL_STATUS) && m_data_byteen[0] && m_data_wdata[4]);
`else
    clr_pending_s = wr_ctrl_lo_s;
`endif
  end

  // Same-cycle read data mux for the M-stage load path
  always_comb begin
    rdata_s = 32'd0;
    if (hit_s) begin
      case (sel_s)
        SEL_CTRL:   rdata_s = {28'd0, ctrl_r};
        SEL_PRESET: rdata_s = preset_r;
        SEL_COUNT:  rdata_s = count_r;
`ifdef TIMER_STATUS_EN
        SEL_STATUS: rdata_s = status_s;
`else
        SEL_STATUS: rdata_s = 32'd0;
`endif
        default:    rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign m_data_rdata = rdata_s;

  // Register file, countdown FSM and interrupt pending flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      ctrl_r    <= 4'h0;
      preset_r  <= PRESET_RST;
      count_r   <= 32'd0;
      pending_r <= 1'b0;
    end else begin
      if (wr_preset_s) begin
        preset_r <= merge_lanes(preset_r, m_data_wdata, m_data_byteen);
      end

      // A CPU write to CTRL lane 0 overrides the one-shot EN clear
      if (wr_ctrl_lo_s) begin
        ctrl_r <= m_data_wdata[3:0];
      end else if (oneshot_s) begin
        ctrl_r[0] <= 1'b0;
      end

      // Setting pending beats any same-cycle software clear
      if (set_pending_s) begin
        pending_r <= 1'b1;
      end else if (reload_s || clr_pending_s) begin
        pending_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (ctrl_r[0]) state_r <= LOAD;
        end
        LOAD: begin
          count_r <= preset_r;
          state_r <= CNT;
        end
        CNT: begin
          if (!ctrl_r[0]) begin
            state_r <= IDLE;
          end else if (count_r <= 32'd1) begin
            count_r <= 32'd0;
            state_r <= INT;
          end else begin
            count_r <= count_r - 32'd1;
          end
        end
        INT: begin
          if (ctrl_r[2:1] == MODE_RELOAD) state_r <= LOAD;
          else                            state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer_responder.sv
// Self-checking bench for bus_timer_responder: randomized directed scenarios
// checked against timing derived arithmetically from the timer's rules.
module tb_bus_timer_responder;

  localparam logic [31:0] BASE  = 32'h0000_7F00;
  localparam logic [31:0] RST_P = 32'h0000_A5C3;

  logic        clk;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
  logic        hit;
  logic        IRQ;

  int          total;
  int          bad;
  logic [7:0]  preset_m [4];
  logic [31:0] c0;
  logic [31:0] a_v;
  logic [31:0] d_v;
  logic [3:0]  be_v;
  int          n_v;

  bus_timer_responder #(
    .BASE_ADDR (BASE),
    .PRESET_RST(RST_P)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m_data_addr  (m_data_addr),
    .m_data_wdata (m_data_wdata),
    .m_data_byteen(m_data_byteen),
    .m_data_rdata (m_data_rdata),
    .hit          (hit),
    .IRQ          (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] off, input logic [31:0] exp);
    m_data_byteen = 4'b0000;
    m_data_addr   = {BASE[31:4], off[3:2], 2'($urandom_range(0, 3))};
    #1;
    check(tag, m_data_rdata, exp);
    check({tag, "_hit"}, {31'd0, hit}, 32'd1);
  endtask

  task automatic irq_check(input string tag, input logic exp);
    check(tag, {31'd0, IRQ}, {31'd0, exp});
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] be);
    m_data_addr   = {BASE[31:4], off[3:2], 2'($urandom_range(0, 3))};
    m_data_wdata  = d;
    m_data_byteen = be;
    @(posedge clk);
    #1;
    m_data_byteen = 4'b0000;
  endtask

  function automatic logic [31:0] preset_exp();
    return {preset_m[3], preset_m[2], preset_m[1], preset_m[0]};
  endfunction

  task automatic load_preset(input logic [31:0] v);
    wr(4'h4, v, 4'hF);
    for (int i = 0; i < 4; i++) preset_m[i] = v[8*i +: 8];
  endtask

  // COUNT k edges after the EN-setting write in a single (non-reloading) run
  function automatic logic [31:0] run_count(input int k, input int n, input logic [31:0] prev);
    int eff;
    eff = (n < 1) ? 1 : n;
    if (k < 2)             return prev;
    else if (k <= eff + 1) return 32'(n - (k - 2));
    else                   return 32'd0;
  endfunction

  task automatic one_shot(input int n);
    int eff;
    eff = (n < 1) ? 1 : n;
    load_preset(32'(n));
    wr(4'h0, 32'h9, 4'h1);
    for (int k = 1; k <= eff + 4; k++) begin
      step(1);
      rd_check($sformatf("os%0d_count_k%0d", n, k), 4'h8, run_count(k, n, c0));
      irq_check($sformatf("os%0d_irq_k%0d", n, k), k >= eff + 2);
      rd_check($sformatf("os%0d_ctrl_k%0d", n, k), 4'h0, (k >= eff + 3) ? 32'h8 : 32'h9);
    end
    c0 = 32'd0;
    wr(4'h0, 32'h8, 4'h1);
    irq_check($sformatf("os%0d_irq_after_ctrl_wr", n), 1'b0);
    rd_check($sformatf("os%0d_ctrl_im", n), 4'h0, 32'h8);
    wr(4'h0, 32'h0, 4'h1);
  endtask

  task automatic auto_reload(input int p);
    int eff;
    int m;
    logic [31:0] ec;
    eff = (p < 1) ? 1 : p;
    load_preset(32'(p));
    wr(4'h0, 32'hB, 4'h1);
    for (int k = 1; k <= 3 * (eff + 2) + 1; k++) begin
      step(1);
      m = (k - 1) % (eff + 2);
      if (m == 0)        ec = (k == 1) ? c0 : 32'd0;
      else if (m <= eff) ec = 32'(p - m + 1);
      else               ec = 32'd0;
      rd_check($sformatf("ar%0d_count_k%0d", p, k), 4'h8, ec);
      irq_check($sformatf("ar%0d_irq_k%0d", p, k), m == eff + 1);
      rd_check($sformatf("ar%0d_ctrl_k%0d", p, k), 4'h0, 32'hB);
    end
    // Loop ends in LOAD: the reload still lands, then CNT sees EN low
    wr(4'h0, 32'h0, 4'h1);
    step(3);
    rd_check($sformatf("ar%0d_stop_count", p), 4'h8, 32'(p));
    irq_check($sformatf("ar%0d_stop_irq", p), 1'b0);
    c0 = 32'(p);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    c0            = 32'd0;
    reset         = 1'b1;
    m_data_addr   = 32'd0;
    m_data_wdata  = 32'd0;
    m_data_byteen = 4'b0000;
    for (int i = 0; i < 4; i++) preset_m[i] = RST_P[8*i +: 8];

    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    rd_check("rst_ctrl", 4'h0, 32'h0);
    rd_check("rst_preset", 4'h4, preset_exp());
    rd_check("rst_count", 4'h8, 32'h0);
    irq_check("rst_irq", 1'b0);
    #2 reset = 1'b1;
    step(2);
    rd_check("post_rst_ctrl", 4'h0, 32'h0);
    rd_check("reg_c_idle", 4'hC, 32'h0);

    load_preset(32'h1122_3344);
    rd_check("preset_full", 4'h4, preset_exp());
    wr(4'h4, 32'hAAAA_AAAA, 4'b0100);
    preset_m[2] = 8'hAA;
    rd_check("preset_lane2", 4'h4, 32'h11AA_3344);
    for (int j = 0; j < 8; j++) begin
      d_v  = $urandom;
      be_v = 4'($urandom_range(0, 15));
      wr(4'h4, d_v, be_v);
      for (int i = 0; i < 4; i++) if (be_v[i]) preset_m[i] = d_v[8*i +: 8];
      rd_check($sformatf("preset_rand%0d_be%h", j, be_v), 4'h4, preset_exp());
    end

    a_v = $urandom;
    if (a_v[31:4] == BASE[31:4]) a_v = a_v ^ 32'h0001_0000;
    m_data_addr = a_v;
    #1;
    check("miss_rdata", m_data_rdata, 32'h0);
    check("miss_hit", {31'd0, hit}, 32'h0);
    m_data_addr   = {a_v[31:4], 4'h4};
    m_data_wdata  = $urandom;
    m_data_byteen = 4'hF;
    @(posedge clk);
    #1;
    m_data_byteen = 4'b0000;
    rd_check("miss_write_ignored", 4'h4, preset_exp());

    wr(4'h0, 32'hFFFF_FFF0, 4'hF);
    rd_check("ctrl_upper_not_stored", 4'h0, 32'h0);
    wr(4'h0, 32'hFFFF_FFFF, 4'b1110);
    rd_check("ctrl_lane0_untouched", 4'h0, 32'h0);
    wr(4'h8, 32'hFFFF_FFFF, 4'hF);
    rd_check("count_write_ignored", 4'h8, 32'h0);
    wr(4'hC, 32'hFFFF_FFEF, 4'hF);
    rd_check("reg_c_write", 4'hC, 32'h0);

    one_shot(3);
    one_shot($urandom_range(0, 6));
    one_shot(0);
    auto_reload(2);
    auto_reload($urandom_range(0, 5));

    // Disable mid-count; a PRESET write during CNT must not touch COUNT
    load_preset(32'd10);
    wr(4'h0, 32'h1, 4'h1);
    step(3);
    rd_check("frz_cnt9", 4'h8, 32'd9);
    load_preset(32'd3);
    rd_check("frz_cnt8", 4'h8, 32'd8);
    step(1);
    rd_check("frz_cnt7", 4'h8, 32'd7);
`ifdef TIMER_STATUS_EN
    rd_check("frz_status_cnt", 4'hC, 32'h2);
`endif
    wr(4'h0, 32'h0, 4'h1);
    rd_check("frz_cnt6", 4'h8, 32'd6);
    step(4);
    rd_check("frz_hold", 4'h8, 32'd6);
    irq_check("frz_irq", 1'b0);
    rd_check("frz_preset", 4'h4, preset_exp());
`ifdef TIMER_STATUS_EN
    rd_check("frz_status_idle", 4'hC, 32'h0);
`endif
    c0 = 32'd6;

    // IM = 0: pending sets internally but IRQ stays low
    n_v = $urandom_range(1, 4);
    load_preset(32'(n_v));
    wr(4'h0, 32'h1, 4'h1);
    for (int k = 1; k <= n_v + 4; k++) begin
      step(1);
      rd_check($sformatf("mask_count_k%0d", k), 4'h8, run_count(k, n_v, c0));
      irq_check($sformatf("mask_irq_k%0d", k), 1'b0);
    end
    rd_check("mask_en_cleared", 4'h0, 32'h0);
`ifdef TIMER_STATUS_EN
    rd_check("mask_status_pending", 4'hC, 32'h10);
`endif
    wr(4'h0, 32'h8, 4'h1);
    irq_check("mask_im_write_clears", 1'b0);
`ifdef TIMER_STATUS_EN
    rd_check("mask_status_cleared", 4'hC, 32'h0);
`endif
    wr(4'h0, 32'h0, 4'h1);
    c0 = 32'd0;

    // CTRL write collides with the pending set, then with the EN clear
    n_v = $urandom_range(1, 4);
    load_preset(32'(n_v));
    wr(4'h0, 32'h9, 4'h1);
    step(n_v + 1);
    rd_check("coll_count1", 4'h8, 32'd1);
    wr(4'h0, 32'h9, 4'h1);
    irq_check("coll_set_wins", 1'b1);
`ifdef TIMER_STATUS_EN
    rd_check("coll_status", 4'hC, 32'h1B);
`endif
    wr(4'h0, 32'h9, 4'h1);
    rd_check("coll_cpu_wins_en", 4'h0, 32'h9);
    irq_check("coll_pending_cleared", 1'b0);
`ifdef TIMER_STATUS_EN
    rd_check("coll_status_idle", 4'hC, 32'h0);
`endif
    wr(4'h0, 32'h0, 4'h1);
    step(3);
    rd_check("coll_final_count", 4'h8, 32'(n_v));
    c0 = 32'(n_v);

`ifdef TIMER_STATUS_EN
    load_preset(32'd1);
    wr(4'h0, 32'h1, 4'h1);
    step(5);
    rd_check("w1c_pending", 4'hC, 32'h10);
    wr(4'hC, 32'h0000_00EF, 4'h1);
    rd_check("w1c_bit4_zero", 4'hC, 32'h10);
    wr(4'hC, 32'h0000_0010, 4'b0010);
    rd_check("w1c_lane0_off", 4'hC, 32'h10);
    wr(4'h0, 32'hFFFF_FF00, 4'b1110);
    rd_check("w1c_ctrl_hi_lanes", 4'hC, 32'h10);
    wr(4'hC, 32'h0000_0010, 4'h1);
    rd_check("w1c_cleared", 4'hC, 32'h0);
    c0 = 32'd0;
`endif

    // Asynchronous reset in the middle of a count
    load_preset(32'd10);
    wr(4'h0, 32'h9, 4'h1);
    step(7);
    rd_check("mid_count5", 4'h8, 32'd5);
    #1 reset = 1'b0;
    #1;
    rd_check("arst_ctrl", 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) preset_m[i] = RST_P[8*i +: 8];
    rd_check("arst_preset", 4'h4, preset_exp());
    rd_check("arst_count", 4'h8, 32'h0);
    irq_check("arst_irq", 1'b0);
    step(2);
    #2 reset = 1'b1;
    step(3);
    rd_check("arst_after_count", 4'h8, 32'h0);
    rd_check("arst_after_ctrl", 4'h0, 32'h0);
    irq_check("arst_after_irq", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_timer_responder.md
Name: bus_timer_responder

Overview:
- Memory-mapped countdown timer that sits on the responder side of the CPU data bus.
- It decodes the M-stage address, write data and byte enables, and applies writes to its registers.
- It returns read data combinationally in the same cycle, so the M-stage load path can use it directly.
- It raises an interrupt line that feeds one HWInt bit of the CPU's CP0.

Parameters:
- BASE_ADDR, 32'h0000_7F00, word-aligned base of the 16-byte register window (bits [3:0] must be 0).
- PRESET_RST, 32'h0000_0000, reset value of the PRESET register.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- m_data_addr  input  32  byte address from the M stage.
- m_data_wdata  input  32  write data, already lane-replicated by the initiator.
- m_data_byteen  input  4  byte write enables; 4'b0000 means no write.
- m_data_rdata  output  32  read data, combinational.
- hit  output  1  address falls inside this block's window.
- IRQ  output  1  interrupt request to HWInt.

Behaviour:
- Decode: hit = (m_data_addr[31:4] == BASE_ADDR[31:4]). m_data_addr[3:2] selects the register; m_data_addr[1:0] is ignored.
- Register map:
  - 0x0 CTRL: bit0 EN, bits[2:1] MODE, bit3 IM; bits[31:4] read 0.
  - 0x4 PRESET: read/write.
  - 0x8 COUNT: read-only.
  - 0xC: see optional feature.
- Write: on clk edge when hit and byteen != 0.
  - Byte lane i of the target register is replaced by wdata[8i+7:8i] when byteen[i] = 1; other lanes are kept.
  - CTRL bits [31:4] are never stored.
  - Writes to COUNT and 0xC are ignored.
- Read: m_data_rdata = selected register when hit, else 32'h0. There is no read side effect and no latency.
- IRQ = pending & IM. This is a registered term ANDed with the live IM bit.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT, priority order:
    - if !EN, go to IDLE with COUNT frozen;
    - else if COUNT <= 1, COUNT <= 0, pending <= 1, go to INT;
    - else COUNT <= COUNT - 1.
  - INT, MODE 2'b00 (one-shot): EN <= 0, go to IDLE. pending stays set until the next CTRL write with byteen[0] = 1.
  - INT, MODE 2'b01 (auto-reload): pending <= 0, go to LOAD. IRQ is a 1-cycle pulse (while in INT).
  - INT, MODE 2'b1x: treated as 2'b00.
- Timing: PRESET = N ≥ 1 gives pending asserted N+2 edges after the EN-setting write.
- PRESET = 0: LOAD -> CNT -> INT. This behaves like PRESET = 1.
- Simultaneous events:
  - A CPU CTRL write in the same cycle as the FSM's EN clear: the CPU value wins.
  - A CTRL write (byteen[0] = 1) in the same cycle as a set of pending: the set wins.
- A PRESET write during CNT does not alter COUNT; it takes effect at the next LOAD.
- A write clearing EN during INT: the INT transition still completes, then the FSM stays in IDLE.
- Reset (asynchronous, active-low):
  - CTRL = 0, PRESET = PRESET_RST, COUNT = 0, pending = 0, state = IDLE.
  - Consequently IRQ = 0 and the registered contents of m_data_rdata read 0 / PRESET_RST.
  - Reset asserted mid-count aborts immediately; there is no pending carry-over.

Optional Feature:
- Macro: TIMER_STATUS_EN.
- Defined: offset 0xC reads STATUS = {27'b0, pending, IRQ, 1'b0, state[1:0]}, with state encoding IDLE = 0, LOAD = 1, CNT = 2, INT = 3.
  - A write to 0xC with byteen[0] = 1 and wdata[4] = 1 clears pending (write-1-to-clear).
  - A set of pending in the same cycle wins.
- Not defined: offset 0xC reads 32'h0 and writes are ignored. No STATUS logic is synthesised.

Test Plan:
- Reset: reset low mid-count with COUNT = 5 -> all outputs and registers return to reset values asynchronously; CTRL reads 0, IRQ = 0.
- Byte-lane write: PRESET = 32'h1122_3344, then write 32'hAAAA_AAAA with byteen 4'b0100 -> PRESET reads 32'h11AA_3344; a read outside the window returns 0 and hit = 0.
- One-shot: PRESET = 3, CTRL = 32'h9 (EN, IM, MODE 0) -> IRQ rises on the 5th edge after the write and holds; EN reads 0; writing CTRL = 0 drops IRQ next cycle.
- Auto-reload: PRESET = 2, CTRL = 32'hB -> IRQ is a 1-cycle pulse every 4 cycles; COUNT sequence 2,1,0,(INT),2,...
- Masking and disable: CTRL = 32'h1 (IM = 0) -> pending set but IRQ stays 0; clearing EN during CNT with COUNT = 7 -> COUNT frozen at its current value, state IDLE.
- Collision: a CTRL write with byteen[0] = 1 in the same cycle pending sets -> pending = 1 afterwards; with TIMER_STATUS_EN, reading 0xC shows bit4 = 1 and a W1C write clears it.
